x_adc_interleave_seq: RTL

Parametrised N-channel time-interleaved ADC sample sequencer. It is the next generation of the 2-channel x_adc select mux. It registers one channel's sample per cycle into the single x_adc stream feeding the downstream filter, either from an external select (manual mode) or from an internal round-robin sequencer that skips disabled channels. It also reports which channel each output sample came from, and flags frame completion.

---
 rtl/x_adc_pkg.sv | 36 +++
 rtl/x_adc_interleave_seq_rr_next_ch.sv | 24 ++
 rtl/x_adc_interleave_seq.sv | 129 ++++++++++++
 3 files changed

// File: rtl/x_adc_pkg.sv
// Shared definitions for the x_adc interleave family: mode encodings,
// sequencer states and the round-robin next-enabled-channel search.
package x_adc_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    // First enabled channel strictly after cur, wrapping modulo n (n <= 16).
    // With no channel enabled the result is cur itself.
    function automatic logic [3:0] next_en_idx(input logic [15:0] en,
                                               input logic [3:0]  cur,
                                               input int unsigned n);
        int unsigned idx;
        logic        found;
        logic [3:0]  res;
        res   = cur;
        found = 1'b0;
        for (int unsigned k = 1; k <= 16; k++) begin
            idx = 32'(cur) + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if (!found && (k <= n) && en[idx[3:0]]) begin
                res   = idx[3:0];
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/x_adc_interleave_seq_rr_next_ch.sv
// Combinational round-robin step: next enabled channel after ptr_i,
// whether that step wraps to an equal-or-lower index, and whether any
// channel is enabled at all.
module rr_next_ch
    import x_adc_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = $clog2(NCH)
) (
    input  logic [CW-1:0]  ptr_i,
    input  logic [NCH-1:0] ch_en_i,
    output logic [CW-1:0]  nxt_o,
    output logic           wrap_o,
    output logic           any_en_o
);

    // Search from ptr_i; a single enabled channel yields nxt == ptr, i.e. a wrap.
    always_comb begin
        nxt_o    = CW'(next_en_idx(16'(ch_en_i), 4'(ptr_i), NCH));
        wrap_o   = (nxt_o <= ptr_i);
        any_en_o = |ch_en_i;
    end

endmodule

// File: rtl/x_adc_interleave_seq.sv
// N-channel interleaved ADC sample sequencer. Registers one channel per
// cycle into the x_adc stream, either from sel_in (manual) or from a
// round-robin pointer that skips disabled channels (auto).
module x_adc_interleave_seq
    import x_adc_pkg::*;
#(
    parameter  int unsigned W   = 32,
    parameter  int unsigned NCH = 4,
    localparam int unsigned CW  = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             GlobalReset,
    input  logic [NCH*W-1:0] x_adc_in,
    input  logic             mode,
    input  logic [CW-1:0]    sel_in,
    input  logic [NCH-1:0]   ch_en,
    input  logic             start,
    input  logic             stop,
    output logic [W-1:0]     x_adc,
    output logic             x_adc_valid,
    output logic [CW-1:0]    x_adc_ch,
    output logic             frame_done,
    output logic             busy
);

    // Enable mask padded to the full index space so out-of-range selects read 0.
    localparam int unsigned NPAD = 1 << CW;

    state_t         state_q, state_d;
    logic [CW-1:0]  ptr_q, ptr_d;
    logic [W-1:0]   x_adc_q, x_adc_d;
    logic [CW-1:0]  ch_q, ch_d;
    logic           valid_q, valid_d;
    logic           fd_q, fd_d;

    logic [NPAD-1:0] en_pad;
    logic [CW-1:0]   nxt_ch;
    logic            nxt_wrap;
    logic            any_en;
    logic [CW-1:0]   first_ch;

    rr_next_ch #(
        .NCH (NCH),
        .CW  (CW)
    ) u_next (
        .ptr_i    (ptr_q),
        .ch_en_i  (ch_en),
        .nxt_o    (nxt_ch),
        .wrap_o   (nxt_wrap),
        .any_en_o (any_en)
    );

    // Pad the mask and find the first enabled channel at or above index 0.
    always_comb begin
        en_pad   = NPAD'(ch_en);
        first_ch = CW'(next_en_idx(16'(ch_en), 4'(NCH - 1), NCH));
    end

    // Next-state and output-register inputs; manual mode overrides the sequencer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        x_adc_d = x_adc_q;
        ch_d    = ch_q;
        valid_d = 1'b0;
        fd_d    = 1'b0;
        if (mode == MODE_MANUAL) begin
            state_d = ST_IDLE;
            ptr_d   = '0;
            if (en_pad[sel_in]) begin
                x_adc_d = x_adc_in[32'(sel_in)*W +: W];
                ch_d    = sel_in;
                valid_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop && any_en) begin
                        state_d = ST_RUN;
                        ptr_d   = first_ch;
                    end
                end
                ST_RUN: begin
                    if (stop || !any_en) begin
                        state_d = ST_IDLE;
                    end else begin
                        ptr_d = nxt_ch;
                        // A channel disabled under the pointer is skipped silently.
                        if (en_pad[ptr_q]) begin
                            x_adc_d = x_adc_in[32'(ptr_q)*W +: W];
                            ch_d    = ptr_q;
                            valid_d = 1'b1;
                            fd_d    = nxt_wrap;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, pointer and output registers.
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            x_adc_q <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            x_adc_q <= x_adc_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            fd_q    <= fd_d;
        end
    end

    assign x_adc       = x_adc_q;
    assign x_adc_valid = valid_q;
    assign x_adc_ch    = ch_q;
    assign frame_done  = fd_q;
    assign busy        = (state_q == ST_RUN);

endmodule
